// File: rtl/sha_seq.sv
// sha_seq: sequences a multi-block SHA-256 job. Message words are read from
// memory, streamed into a SHA peripheral, the peripheral is polled for block
// completion, and the final digest is read back into hash_o.
// Optional feature: define SHA_SEQ_TIMEOUT_EN to bound the completion poll
// (256 consecutive not-done reads set the sticky err_o and end the job).
module sha_seq (
   input  logic         CLK_I,
   input  logic         RST_I,
   input  logic         start_i,
   input  logic [31:0]  src_adr_i,
   input  logic [7:0]   nblk_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o,
   output logic [255:0] hash_o,
   output logic         MEM_STB_O,
   output logic [31:0]  MEM_ADR_O,
   input  logic         MEM_ACK_I,
   input  logic [31:0]  MEM_DAT_I,
   output logic         M_STB_O,
   output logic         M_WE_O,
   output logic [4:0]   M_ADR_O,
   output logic [31:0]  M_DAT_O,
   input  logic         M_ACK_I,
   input  logic [31:0]  M_DAT_I
);

   localparam logic [4:0] REG_CMD  = 5'h00;
   localparam logic [4:0] REG_DIN  = 5'h04;
   localparam logic [4:0] REG_HASH = 5'h08;

   typedef enum logic [2:0] {IDLE, INIT, FETCH, FEED, POLL, READ, FIN} state_t;

   state_t         state_r;
   logic [31:0]    blk_adr_r;
   logic [7:0]     blk_left_r;
   logic [3:0]     word_cnt_r;
   logic [2:0]     hash_cnt_r;
   logic [31:0]    word_r;
   logic           busy_r;
   logic           done_r;
   logic [255:0]   hash_r;
   logic           mem_stb_r;
   logic [31:0]    mem_adr_r;
   logic           m_stb_r;
   logic           m_we_r;
   logic [4:0]     m_adr_r;
   logic [31:0]    m_dat_r;
`ifdef SHA_SEQ_TIMEOUT_EN
   logic           err_r;
   logic [7:0]     poll_cnt_r;
`endif

   // Job sequencer: every bus strobe is raised from a state where it is low,
   // so each acknowledged transaction is followed by at least one idle cycle.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_r    <= IDLE;
         blk_adr_r  <= 32'd0;
         blk_left_r <= 8'd0;
         word_cnt_r <= 4'd0;
         hash_cnt_r <= 3'd0;
         word_r     <= 32'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         hash_r     <= 256'd0;
         mem_stb_r  <= 1'b0;
         mem_adr_r  <= 32'd0;
         m_stb_r    <= 1'b0;
         m_we_r     <= 1'b0;
         m_adr_r    <= 5'd0;
         m_dat_r    <= 32'd0;
`ifdef SHA_SEQ_TIMEOUT_EN
         err_r      <= 1'b0;
         poll_cnt_r <= 8'd0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start_i) begin
                  blk_adr_r  <= src_adr_i;
                  blk_left_r <= nblk_i;
                  word_cnt_r <= 4'd0;
                  hash_cnt_r <= 3'd0;
                  busy_r     <= 1'b1;
`ifdef SHA_SEQ_TIMEOUT_EN
                  err_r      <= 1'b0;
`endif
                  if (nblk_i != 8'd0) begin
                     // Init command goes out in the first INIT cycle.
                     state_r <= INIT;
                     m_stb_r <= 1'b1;
                     m_we_r  <= 1'b1;
                     m_adr_r <= REG_CMD;
                     m_dat_r <= 32'h0000_0001;
                  end else begin
                     state_r <= FIN;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            INIT: begin
               if (m_stb_r && M_ACK_I) begin
                  m_stb_r <= 1'b0;
                  m_we_r  <= 1'b0;
                  state_r <= FETCH;
               end else begin
                  state_r <= INIT;
               end
            end
            FETCH: begin
               if (!mem_stb_r) begin
                  mem_stb_r <= 1'b1;
                  mem_adr_r <= blk_adr_r + {26'd0, word_cnt_r, 2'b00};
               end else if (MEM_ACK_I) begin
                  mem_stb_r <= 1'b0;
                  word_r    <= MEM_DAT_I;
                  state_r   <= FEED;
               end else begin
                  state_r   <= FETCH;
               end
            end
            FEED: begin
               if (!m_stb_r) begin
                  m_stb_r <= 1'b1;
                  m_we_r  <= 1'b1;
                  m_adr_r <= REG_DIN;
                  m_dat_r <= word_r;
               end else if (M_ACK_I) begin
                  m_stb_r    <= 1'b0;
                  m_we_r     <= 1'b0;
                  word_cnt_r <= word_cnt_r + 4'd1;
                  if (word_cnt_r == 4'd15) begin
                     state_r <= POLL;
`ifdef SHA_SEQ_TIMEOUT_EN
                     poll_cnt_r <= 8'd0;
`endif
                  end else begin
                     state_r <= FETCH;
                  end
               end else begin
                  state_r <= FEED;
               end
            end
            POLL: begin
               if (!m_stb_r) begin
                  m_stb_r <= 1'b1;
                  m_we_r  <= 1'b0;
                  m_adr_r <= REG_CMD;
                  m_dat_r <= 32'd0;
               end else if (M_ACK_I) begin
                  m_stb_r <= 1'b0;
                  if (M_DAT_I[1]) begin
                     if (blk_left_r != 8'd1) begin
                        // Next block sits 64 bytes further on, wrapping at 2^32.
                        blk_left_r <= blk_left_r - 8'd1;
                        blk_adr_r  <= blk_adr_r + 32'd64;
                        state_r    <= FETCH;
                     end else begin
                        hash_cnt_r <= 3'd0;
                        state_r    <= READ;
                     end
                  end else begin
`ifdef SHA_SEQ_TIMEOUT_EN
                     if (poll_cnt_r == 8'd255) begin
                        err_r   <= 1'b1;
                        state_r <= FIN;
                     end else begin
                        poll_cnt_r <= poll_cnt_r + 8'd1;
                        state_r    <= POLL;
                     end
`else
                     state_r <= POLL;
`endif
                  end
               end else begin
                  state_r <= POLL;
               end
            end
            READ: begin
               if (!m_stb_r) begin
                  m_stb_r <= 1'b1;
                  m_we_r  <= 1'b0;
                  m_adr_r <= REG_HASH;
                  m_dat_r <= 32'd0;
               end else if (M_ACK_I) begin
                  // H0 arrives first and ends up in the top word after eight shifts.
                  m_stb_r    <= 1'b0;
                  hash_r     <= {hash_r[223:0], M_DAT_I};
                  hash_cnt_r <= hash_cnt_r + 3'd1;
                  if (hash_cnt_r == 3'd7) begin
                     state_r <= FIN;
                  end else begin
                     state_r <= READ;
                  end
               end else begin
                  state_r <= READ;
               end
            end
            FIN: begin
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               m_stb_r   <= 1'b0;
               mem_stb_r <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   assign busy_o    = busy_r;
   assign done_o    = done_r;
   assign hash_o    = hash_r;
   assign MEM_STB_O = mem_stb_r;
   assign MEM_ADR_O = mem_adr_r;
   assign M_STB_O   = m_stb_r;
   assign M_WE_O    = m_we_r;
   assign M_ADR_O   = m_adr_r;
   assign M_DAT_O   = m_dat_r;
`ifdef SHA_SEQ_TIMEOUT_EN
   assign err_o     = err_r;
`else
   assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_sha_seq.sv
// Bench for sha_seq: memory and SHA-peripheral slave models with random
// acknowledge latency, a SHA-256 reference computed from memory contents,
// and a done-triggered scoreboard. Covers the SHA_SEQ_TIMEOUT_EN build too.
module tb_sha_seq;

   logic         CLK_I = 1'b0;
   logic         RST_I = 1'b1;
   logic         start_i = 1'b0;
   logic [31:0]  src_adr_i = 32'd0;
   logic [7:0]   nblk_i = 8'd0;
   logic         busy_o, done_o, err_o;
   logic [255:0] hash_o;
   logic         MEM_STB_O;
   logic [31:0]  MEM_ADR_O;
   logic         MEM_ACK_I = 1'b0;
   logic [31:0]  MEM_DAT_I = 32'd0;
   logic         M_STB_O, M_WE_O;
   logic [4:0]   M_ADR_O;
   logic [31:0]  M_DAT_O;
   logic         M_ACK_I = 1'b0;
   logic [31:0]  M_DAT_I = 32'd0;

   sha_seq dut (
      .CLK_I(CLK_I), .RST_I(RST_I), .start_i(start_i), .src_adr_i(src_adr_i),
      .nblk_i(nblk_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .hash_o(hash_o), .MEM_STB_O(MEM_STB_O), .MEM_ADR_O(MEM_ADR_O),
      .MEM_ACK_I(MEM_ACK_I), .MEM_DAT_I(MEM_DAT_I), .M_STB_O(M_STB_O),
      .M_WE_O(M_WE_O), .M_ADR_O(M_ADR_O), .M_DAT_O(M_DAT_O),
      .M_ACK_I(M_ACK_I), .M_DAT_I(M_DAT_I)
   );

   always #5 CLK_I = ~CLK_I;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [255:0] ABC_HASH =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

   typedef struct { logic [255:0] h; logic e; } exp_t;
   exp_t         exp_q [$];
   logic [31:0]  exp_adr [$];
   logic [31:0]  mem [logic [31:0]];

   int n_chk = 0, n_fail = 0;
   int n_init, n_din, n_cmd, n_hash, n_mem, n_done, n_mstb, n_memstb;
   bit force_m10 = 0, force_mem10 = 0;
   logic [255:0] p_h = '0;
   logic [511:0] p_buf = '0;
   int  p_cnt = 0, p_hidx = 0, p_notdone = 0;
   bit  p_never = 0;
   logic [255:0] last_hash = '0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic fail_line(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Plain SHA-256 compression of one 512-bit block (word 0 in the top bits).
   function automatic logic [255:0] sha_block(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      {a, b, c, d, e, f, g, h} = hin;
      for (int i = 0; i < 64; i++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'd0;
   endfunction

   // SHA peripheral register behaviour on an acknowledged access.
   task automatic m_do();
      if (M_WE_O && M_ADR_O == 5'h00) begin
         n_init++;
         chk("init_data", M_DAT_O, 256'd1);
         p_h = IV; p_cnt = 0; p_hidx = 0;
      end else if (M_WE_O && M_ADR_O == 5'h04) begin
         n_din++;
         p_buf = {p_buf[479:0], M_DAT_O};
         p_cnt++;
         if (p_cnt == 16) begin
            p_h = sha_block(p_h, p_buf);
            p_cnt = 0;
            p_notdone = $urandom_range(0, 3);
         end
      end else if (!M_WE_O && M_ADR_O == 5'h00) begin
         n_cmd++;
         M_DAT_I = $urandom & 32'hFFFF_FFFD;
         if (p_never || p_notdone > 0) begin
            if (p_notdone > 0) p_notdone--;
         end else begin
            M_DAT_I = M_DAT_I | 32'h2;
         end
      end else if (!M_WE_O && M_ADR_O == 5'h08) begin
         n_hash++;
         M_DAT_I = p_h[255 - 32*p_hidx -: 32];
         p_hidx = (p_hidx + 1) % 8;
      end else begin
         fail_line("m_bad_access");
      end
   endtask

   // SHA peripheral slave: random latency, checks strobe stability and drop.
   initial begin : m_slave
      int wcnt, dly;
      bit held;
      logic [37:0] lat;
      wcnt = 0; dly = 0; held = 0; lat = '0;
      forever begin
         @(negedge CLK_I);
         if (RST_I) begin
            M_ACK_I = 1'b0; held = 0;
         end else if (M_ACK_I) begin
            M_ACK_I = 1'b0; held = 0;
            chk("m_stb_drop", {255'd0, M_STB_O}, 256'd0);
         end else if (M_STB_O) begin
            if (!held) begin
               held = 1; wcnt = 0; n_mstb++;
               lat = {M_ADR_O, M_WE_O, M_DAT_O};
               if (force_m10) begin dly = 10; force_m10 = 0; end
               else dly = $urandom_range(0, 2);
            end else begin
               chk("m_stable", {218'd0, M_ADR_O, M_WE_O, M_DAT_O}, {218'd0, lat});
            end
            if (wcnt >= dly) begin m_do(); M_ACK_I = 1'b1; end
            else wcnt++;
         end
      end
   end

   // Memory slave: random latency, checks address order against the scoreboard.
   initial begin : mem_slave
      int wcnt, dly;
      bit held;
      logic [31:0] lat;
      wcnt = 0; dly = 0; held = 0; lat = '0;
      forever begin
         @(negedge CLK_I);
         if (RST_I) begin
            MEM_ACK_I = 1'b0; held = 0;
         end else if (MEM_ACK_I) begin
            MEM_ACK_I = 1'b0; held = 0;
            chk("mem_stb_drop", {255'd0, MEM_STB_O}, 256'd0);
         end else if (MEM_STB_O) begin
            if (!held) begin
               held = 1; wcnt = 0; n_memstb++; lat = MEM_ADR_O;
               if (force_mem10) begin dly = 10; force_mem10 = 0; end
               else dly = $urandom_range(0, 3);
            end else begin
               chk("mem_stable", {224'd0, MEM_ADR_O}, {224'd0, lat});
            end
            if (wcnt >= dly) begin
               n_mem++;
               if (exp_adr.size() == 0) fail_line("mem_unexpected_read");
               else chk("mem_adr", {224'd0, MEM_ADR_O}, {224'd0, exp_adr.pop_front()});
               MEM_DAT_I = mem_rd(MEM_ADR_O);
               MEM_ACK_I = 1'b1;
            end else wcnt++;
         end
      end
   end

   // Scoreboard monitor: every done pulse consumes one expected result.
   initial begin : done_mon
      exp_t e;
      forever begin
         @(negedge CLK_I);
         if (!RST_I && done_o) begin
            n_done++;
            if (exp_q.size() == 0) fail_line("unexpected_done");
            else begin
               e = exp_q.pop_front();
               chk("hash_o", hash_o, e.h);
               chk("err_o", {255'd0, err_o}, {255'd0, e.e});
            end
         end
      end
   end

   task automatic load_msg(input logic [31:0] src, input int nb, input bit abc);
      for (int i = 0; i < 16*nb; i++) begin
         if (abc) mem[src + 32'(4*i)] = (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h18 : 32'h0);
         else     mem[src + 32'(4*i)] = $urandom;
      end
   endtask

   task automatic run_job(input logic [31:0] src, input int nb, input bit to,
                          input bit poke, input bit rst7);
      logic [255:0] h;
      logic [511:0] blk;
      logic [31:0]  a;
      exp_t e;
      int cyc, fed_blks;
      bit done_seen, pk_feed, pk_fin;
      h = IV;
      fed_blks = to ? 1 : nb;
      for (int b = 0; b < nb; b++) begin
         blk = '0;
         for (int i = 0; i < 16; i++) begin
            a = src + 32'(64*b + 4*i);
            blk = {blk[479:0], mem_rd(a)};
            if (b < fed_blks) exp_adr.push_back(a);
         end
         h = sha_block(h, blk);
      end
      e.h = (nb == 0 || to) ? last_hash : h;
      e.e = to;
      exp_q.push_back(e);
      n_init = 0; n_din = 0; n_cmd = 0; n_hash = 0; n_mem = 0; n_done = 0; n_mstb = 0; n_memstb = 0;
      @(posedge CLK_I); #1;
      start_i = 1'b1; src_adr_i = src; nblk_i = 8'(nb);
      cyc = 0; done_seen = 0; pk_feed = 0; pk_fin = 0;
      while (!done_seen && cyc < 8000) begin
         @(posedge CLK_I); #1;
         cyc++;
         start_i = 1'b0;
         if (done_o) done_seen = 1;
         else if (rst7 && n_din == 7) begin
            RST_I = 1'b1;
            #1;
            chk("reset_outputs", {181'd0, busy_o, done_o, err_o, MEM_STB_O, MEM_ADR_O,
                                  M_STB_O, M_WE_O, M_ADR_O, M_DAT_O}, 256'd0);
            chk("reset_hash", hash_o, 256'd0);
            exp_q.delete(); exp_adr.delete(); last_hash = '0;
            repeat (2) @(posedge CLK_I);
            #1 RST_I = 1'b0;
            return;
         end else if (poke && !pk_feed && M_STB_O && M_WE_O && M_ADR_O == 5'h04) begin
            start_i = 1'b1; nblk_i = 8'd3; src_adr_i = 32'hDEAD_0000; pk_feed = 1;
         end else if (poke && !pk_fin && n_hash == 8 && !M_STB_O) begin
            start_i = 1'b1; pk_fin = 1;
         end
      end
      start_i = 1'b0;
      chk("done_seen", {255'd0, done_seen}, 256'd1);
      if (nb == 0) chk("zero_len_latency", {255'd0, cyc <= 2}, 256'd1);
      repeat (6) @(posedge CLK_I);
      #1;
      chk("done_count", 256'(n_done), 256'd1);
      chk("init_writes", 256'(n_init), (nb != 0) ? 256'd1 : 256'd0);
      chk("din_writes", 256'(n_din), 256'(16*fed_blks));
      chk("mem_reads", 256'(n_mem), 256'(16*fed_blks));
      chk("hash_reads", 256'(n_hash), (nb == 0 || to) ? 256'd0 : 256'd8);
      if (to) chk("poll_reads", 256'(n_cmd), 256'd256);
      else chk("poll_reads_min", {255'd0, n_cmd >= nb}, 256'd1);
      if (nb == 0) chk("zero_len_strobes", 256'(n_mstb + n_memstb), 256'd0);
      if (poke) chk("poke_hit", {254'd0, pk_feed, pk_fin}, 256'd3);
      chk("busy_after", {255'd0, busy_o}, 256'd0);
      chk("adr_drained", 256'(exp_adr.size()), 256'd0);
      last_hash = e.h;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] src;
      repeat (3) @(posedge CLK_I);
      #1;
      chk("rst_outputs", {181'd0, busy_o, done_o, err_o, MEM_STB_O, MEM_ADR_O,
                          M_STB_O, M_WE_O, M_ADR_O, M_DAT_O}, 256'd0);
      chk("rst_hash", hash_o, 256'd0);
      RST_I = 1'b0;

      load_msg(32'h0000_0100, 1, 1);
      force_m10 = 1; force_mem10 = 1;
      run_job(32'h0000_0100, 1, 0, 0, 0);
      chk("abc_hash", hash_o, ABC_HASH);

      load_msg(32'h0000_1000, 2, 0);
      run_job(32'h0000_1000, 2, 0, 0, 0);

      run_job(32'h0000_4000, 0, 0, 0, 0);

      load_msg(32'h0000_2000, 1, 0);
      run_job(32'h0000_2000, 1, 0, 1, 0);

      load_msg(32'hFFFF_FFC0, 2, 0);
      run_job(32'hFFFF_FFC0, 2, 0, 0, 0);

      load_msg(32'h0000_0200, 1, 1);
      run_job(32'h0000_0200, 1, 0, 0, 1);
      chk("post_reset_busy", {255'd0, busy_o}, 256'd0);
      run_job(32'h0000_0200, 1, 0, 0, 0);
      chk("abc_after_reset", hash_o, ABC_HASH);

      for (int j = 0; j < 3; j++) begin
         src = $urandom & 32'hFFFF_FFFC;
         load_msg(src, j + 1, 0);
         run_job(src, j + 1, 0, 0, 0);
      end

`ifdef SHA_SEQ_TIMEOUT_EN
      load_msg(32'h0000_3000, 1, 0);
      p_never = 1;
      run_job(32'h0000_3000, 1, 1, 0, 0);
      p_never = 0;
      chk("err_sticky", {255'd0, err_o}, 256'd1);
      load_msg(32'h0000_3400, 1, 0);
      run_job(32'h0000_3400, 1, 0, 0, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sha_seq.md
SHA_SEQ -- requirements
Module: sha_seq

Interface
REQ-001 The block SHALL use reset RST_I (asynchronous, active-high) and clock CLK_I.
REQ-002 The ports SHALL be, clock and reset first:
- CLK_I  in  1  system clock
- RST_I  in  1  async active-high reset
- start_i  in  1  one-cycle job start pulse
- src_adr_i  in  32  byte address of first message word, word aligned
- nblk_i  in  8  number of 512-bit blocks to hash
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job completion pulse
- err_o  out  1  sticky poll timeout flag (macro only, else 0)
- hash_o  out  256  result; H0 in [255:224], H7 in [31:0]
- MEM_STB_O  out  1  memory read request
- MEM_ADR_O  out  32  memory byte address
- MEM_ACK_I  in  1  memory read acknowledge
- MEM_DAT_I  in  32  memory read data
- M_STB_O  out  1  SHA peripheral strobe
- M_WE_O  out  1  SHA peripheral write enable
- M_ADR_O  out  5  SHA peripheral register address
- M_DAT_O  out  32  SHA peripheral write data
- M_ACK_I  in  1  SHA peripheral acknowledge
- M_DAT_I  in  32  SHA peripheral read data

Function
REQ-003 SHA peripheral map SHALL be: 0x00 CMD (write bit0 = init; read bit1 = done), 0x04 DIN, 0x08 HASH (eight sequential reads give H0..H7).
REQ-004 Both master ports SHALL carry one transaction at a time: STB held with stable ADR/WE/DAT until ACK is sampled high, STB low in the following cycle, and at least one idle cycle between transactions.
REQ-005 Read data SHALL be captured in the cycle ACK is sampled high.
REQ-006 FSM states SHALL be IDLE, INIT, FETCH, FEED, POLL, READ, FIN.
REQ-007 IDLE: start_i with nblk_i != 0 SHALL latch src_adr_i and nblk_i, set busy_o, and go to INIT. M_STB_O SHALL rise the next cycle with ADR 0x00, WE 1, DAT 0x00000001.
REQ-008 IDLE: start_i with nblk_i == 0 SHALL go directly to FIN with no bus activity.
REQ-009 INIT SHALL go to FETCH on M_ACK_I.
REQ-010 FETCH SHALL read MEM_ADR_O = base + 4*word_cnt, then go to FEED.
REQ-011 FEED SHALL write the fetched word to DIN (0x04) and increment word_cnt (4-bit, wraps 15->0). After word 15 it SHALL go to POLL, otherwise to FETCH.
REQ-012 POLL SHALL read CMD repeatedly.
- M_DAT_I[1]=1 and blocks remaining: decrement block count, go to FETCH.
- M_DAT_I[1]=1 and last block: go to READ.
- M_DAT_I[1]=0: poll again after the mandatory idle cycle.
REQ-013 The memory address SHALL advance by 64 bytes per block, across the full 32-bit space with wrap modulo 2^32.
REQ-014 READ SHALL perform exactly eight reads of 0x08, shifting each word into hash_o from the LSB side so the first word ends in [255:224], then go to FIN.
REQ-015 FIN SHALL pulse done_o for one cycle, clear busy_o, and return to IDLE. hash_o SHALL hold its value until the next job's first HASH read.
REQ-016 start_i while busy_o=1 SHALL be ignored. start_i in the FIN cycle SHALL also be ignored.
REQ-017 Outputs SHALL change only on the CLK_I rising edge, except on reset.

Reset
REQ-018 Asserting RST_I at any time, including mid-transaction, SHALL return the block to IDLE with all outputs 0: STB, WE, busy_o, done_o, err_o, hash_o, addresses and data.
REQ-019 After reset the first job SHALL begin with the CMD init write; no partial-block state SHALL survive reset.

Configuration
REQ-020 Macro SHA_SEQ_TIMEOUT_EN SHALL control a poll timeout.
- Defined: an 8-bit poll counter, cleared on entry to POLL. The 256th consecutive not-done read SHALL set err_o (sticky until next accepted start_i), and the FSM SHALL go to FIN. done_o still pulses; hash_o is not updated.
- Undefined: POLL waits indefinitely, err_o is tied 0, and no counter is built.

Verification
REQ-021 Single block "abc": memory words 0x61626380, 14x 0x00000000, 0x00000018, nblk=1 -> bus sequence 1 init write, 16 DIN writes, >=1 CMD read, 8 HASH reads; hash_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; done_o pulses once.
REQ-022 Two-block job with nblk=2, src_adr=0x1000 -> memory reads 0x1000..0x107C in order, exactly 32 DIN writes, one init write, hash matches the software model.
REQ-023 nblk=0 -> done_o pulses within 2 cycles of start_i, zero MEM/M strobes.
REQ-024 RST_I asserted after the 7th DIN write of a block -> all outputs 0 immediately. A new nblk=1 "abc" job then returns the REQ-021 hash.
REQ-025 start_i pulsed during FEED -> ignored; exactly one done_o pulse. Slave holding ACK off for 10 cycles -> STB and ADR remain stable.
REQ-026 With SHA_SEQ_TIMEOUT_EN, a slave that never sets done -> err_o=1 after 256 polls, done_o pulses, hash_o unchanged.
